// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC3 memory responder.
//   lat_state_e : per-channel wait-state FSM encoding
//   LFSR_TAPS   : Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
//   T_*_DEF     : default maximum wait states (zero-wait)
//   lfsr_step() : one LFSR advance
package lc3_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lat_state_e;

  // Tap positions 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned T_FETCH_DEF = 0;
  localparam int unsigned T_DATA_DEF  = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lc3_mem_lat_fsm.sv
// Wait-state engine for one memory channel.
//   clk, rst    : clock, async active-high reset
//   req_i       : request, held by the core until complete
//   lat_i       : latency for a request starting this cycle
//   pay_i       : payload (address, and for data also rd flag + write data)
//   start_o     : request accepted this cycle (IDLE and req)
//   complete_o  : access done this cycle
//   pay_o       : payload belonging to the completing access
module lc3_mem_lat_fsm
  import lc3_mem_responder_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int PAY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [CNT_W-1:0] lat_i,
  input  logic [PAY_W-1:0] pay_i,
  output logic             start_o,
  output logic             complete_o,
  output logic [PAY_W-1:0] pay_o
);

  lat_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PAY_W-1:0] pay_q;
  logic             zero_wait;

  assign start_o    = (state_q == ST_IDLE) && req_i;
  assign zero_wait  = start_o && (lat_i == '0);
  // Zero-wait accesses complete combinationally on the live payload.
  assign complete_o = !rst && (zero_wait || state_q == ST_DONE);
  assign pay_o      = zero_wait ? pay_i : pay_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i && lat_i != '0) begin
            state_q <= ST_WAIT;
            cnt_q   <= lat_i;
            pay_q   <= pay_i;
          end
        end
        ST_WAIT: begin
          if (!req_i) begin
            // Core withdrew the request: abandon silently.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Instruction/data memory slave for the LC3 core with programmable wait states.
//   clock, reset            : clock, async active-high reset
//   pc, instrmem_rd         : fetch request  -> Instr_dout, complete_instr
//   Data_addr/din/rd, data_req : data request -> Data_dout, complete_data
//   load_en/addr/data       : preload write port, wins over core writes
// Outputs read zero whenever their complete is low.
module lc3_mem_responder
  import lc3_mem_responder_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int unsigned T_FETCH_MAX = T_FETCH_DEF,
  parameter int unsigned T_DATA_MAX  = T_DATA_DEF,
  parameter int unsigned RAND_LAT    = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  input  logic        Data_rd,
  input  logic        data_req,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int FCW   = $clog2(T_FETCH_MAX + 2);
  localparam int DCW   = $clog2(T_DATA_MAX + 2);
  localparam int DPW   = ADDR_W + 17;  // {rd, addr, wdata}

  logic [15:0]       mem_q [2**ADDR_W];
  logic [15:0]       lfsr_q, lfsr_d, lfsr_f;
  logic              f_start, d_start;
  logic [FCW-1:0]    f_lat;
  logic [DCW-1:0]    d_lat;
  logic [ADDR_W-1:0] f_addr;
  logic [DPW-1:0]    d_pay;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              d_rd, wr_commit;

  // Fetch takes the current LFSR value; a data request starting in the same
  // cycle takes the value after the fetch's advance.
  assign lfsr_f = f_start ? lfsr_step(lfsr_q) : lfsr_q;
  assign lfsr_d = d_start ? lfsr_step(lfsr_f) : lfsr_f;

  assign f_lat = (RAND_LAT != 0) ? FCW'(lfsr_q % (T_FETCH_MAX + 1)) : FCW'(T_FETCH_MAX);
  assign d_lat = (RAND_LAT != 0) ? DCW'(lfsr_f % (T_DATA_MAX + 1))  : DCW'(T_DATA_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  lc3_mem_lat_fsm #(.CNT_W(FCW), .PAY_W(ADDR_W)) u_fetch (
    .clk        (clock),
    .rst        (reset),
    .req_i      (instrmem_rd),
    .lat_i      (f_lat),
    .pay_i      (pc[ADDR_W-1:0]),
    .start_o    (f_start),
    .complete_o (complete_instr),
    .pay_o      (f_addr)
  );

  lc3_mem_lat_fsm #(.CNT_W(DCW), .PAY_W(DPW)) u_data (
    .clk        (clock),
    .rst        (reset),
    .req_i      (data_req),
    .lat_i      (d_lat),
    .pay_i      ({Data_rd, Data_addr[ADDR_W-1:0], Data_din}),
    .start_o    (d_start),
    .complete_o (complete_data),
    .pay_o      (d_pay)
  );

  assign d_rd      = d_pay[DPW-1];
  assign d_addr    = d_pay[DPW-2:16];
  assign d_wdata   = d_pay[15:0];
  assign wr_commit = complete_data && !d_rd;

  // Both reads are asynchronous, so a same-cycle write is seen next cycle.
  assign Instr_dout = complete_instr ? mem_q[f_addr] : 16'h0000;
  assign Data_dout  = complete_data  ? mem_q[d_addr] : 16'h0000;

  // Memory is never reset. Preload is issued last so it overrides a core
  // write to the same word.
  always_ff @(posedge clock) begin
    if (wr_commit) mem_q[d_addr] <= d_wdata;
    if (load_en)   mem_q[load_addr[ADDR_W-1:0]] <= load_data;
  end

endmodule
